// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring divide, one step per cycle.
// Optional macro FAST_MUL_EN: MUL* ops use a single-cycle array multiplier instead of the iterative path.
module muldiv_unit #(
   parameter int DATA_WIDTH      = 32,
   parameter int REG_ADDR_LENGTH = 5
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       start_e_i,
   input  logic [2:0]                 op_e_i,
   input  logic [DATA_WIDTH-1:0]      src_a_e_i,
   input  logic [DATA_WIDTH-1:0]      src_b_e_i,
   input  logic [REG_ADDR_LENGTH-1:0] rd_e_i,
   input  logic                       flush_e_i,
   output logic                       busy_o,
   output logic                       done_o,
   output logic [DATA_WIDTH-1:0]      result_o,
   output logic [REG_ADDR_LENGTH-1:0] rd_o
);

   localparam int W     = DATA_WIDTH;
   localparam int CNT_W = $clog2(DATA_WIDTH) + 1;
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(DATA_WIDTH);
   localparam logic [W-1:0]     MIN_NEG  = {1'b1, {(W-1){1'b0}}};

   localparam logic [2:0] OP_MUL    = 3'd0;
   localparam logic [2:0] OP_MULH   = 3'd1;
   localparam logic [2:0] OP_MULHSU = 3'd2;
   localparam logic [2:0] OP_DIV    = 3'd4;
   localparam logic [2:0] OP_REM    = 3'd6;

   typedef enum logic [1:0] {
      S_IDLE,
      S_BUSY,
      S_DONE
   } state_t;

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [W-1:0]         hi_q, hi_d;
   logic [W-1:0]         lo_q, lo_d;
   logic [W-1:0]         opnd_q, opnd_d;
   logic [2:0]           op_q, op_d;
   logic                 negq_q, negq_d;
   logic                 negr_q, negr_d;
   logic [W-1:0]         result_q, result_d;
   logic [REG_ADDR_LENGTH-1:0] rd_q, rd_d;

   logic                 a_sgn, b_sgn, a_neg, b_neg;
   logic [W-1:0]         a_mag, b_mag;
   logic                 div_zero, div_ovf;
   logic [2*W-1:0]       mstep, dstep, step;
   logic [W-1:0]         hi_n, lo_n, result_fin;

   // One shift-add step: {hi,lo} holds partial product in hi and remaining multiplier bits in lo.
   function automatic logic [2*W-1:0] mul_step(input logic [W-1:0] hi, input logic [W-1:0] lo,
                                               input logic [W-1:0] mcand);
      logic [W:0] sum;
      sum = lo[0] ? ({1'b0, hi} + {1'b0, mcand}) : {1'b0, hi};
      return {sum, lo[W-1:1]};
   endfunction

   // One restoring step: hi is the partial remainder, lo shifts dividend bits out and quotient bits in.
   function automatic logic [2*W-1:0] div_step(input logic [W-1:0] rem, input logic [W-1:0] quo,
                                               input logic [W-1:0] dvsr);
      logic [W:0]   sh;
      logic [W-1:0] diff;
      sh   = {rem, quo[W-1]};
      diff = sh[W-1:0] - dvsr;
      if (sh >= {1'b0, dvsr}) return {diff, quo[W-2:0], 1'b1};
      else                    return {sh[W-1:0], quo[W-2:0], 1'b0};
   endfunction

   function automatic logic [W-1:0] mul_result(input logic [2:0] op, input logic neg,
                                               input logic [2*W-1:0] prod);
      logic [2*W-1:0] p;
      p = neg ? (~prod + 1'b1) : prod;
      return (op == OP_MUL) ? p[W-1:0] : p[2*W-1:W];
   endfunction

   function automatic logic [W-1:0] div_result(input logic [2:0] op, input logic negq, input logic negr,
                                               input logic [W-1:0] rem, input logic [W-1:0] quo);
      if (op[1]) return negr ? (~rem + 1'b1) : rem;
      else       return negq ? (~quo + 1'b1) : quo;
   endfunction

   always_comb begin
      a_sgn    = (op_e_i == OP_MULH) || (op_e_i == OP_MULHSU) || (op_e_i == OP_DIV) || (op_e_i == OP_REM);
      b_sgn    = (op_e_i == OP_MULH) || (op_e_i == OP_DIV) || (op_e_i == OP_REM);
      a_neg    = a_sgn & src_a_e_i[W-1];
      b_neg    = b_sgn & src_b_e_i[W-1];
      a_mag    = a_neg ? (~src_a_e_i + 1'b1) : src_a_e_i;
      b_mag    = b_neg ? (~src_b_e_i + 1'b1) : src_b_e_i;
      div_zero = op_e_i[2] && (src_b_e_i == '0);
      div_ovf  = ((op_e_i == OP_DIV) || (op_e_i == OP_REM)) &&
                 (src_a_e_i == MIN_NEG) && (src_b_e_i == '1);
   end

`ifdef FAST_MUL_EN
   logic [2*W-1:0] fa, fb, fprod;

   // Operands are sign- or zero-extended to 2W bits so the truncated product is exact.
   always_comb begin
      fa    = {{W{a_sgn & src_a_e_i[W-1]}}, src_a_e_i};
      fb    = {{W{b_sgn & src_b_e_i[W-1]}}, src_b_e_i};
      fprod = fa * fb;
   end
`endif

   always_comb begin
      mstep      = mul_step(hi_q, lo_q, opnd_q);
      dstep      = div_step(hi_q, lo_q, opnd_q);
      step       = op_q[2] ? dstep : mstep;
      hi_n       = step[2*W-1:W];
      lo_n       = step[W-1:0];
      result_fin = op_q[2] ? div_result(op_q, negq_q, negr_q, hi_n, lo_n)
                           : mul_result(op_q, negq_q, step);
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      opnd_d   = opnd_q;
      op_d     = op_q;
      negq_d   = negq_q;
      negr_d   = negr_q;
      result_d = result_q;
      rd_d     = rd_q;
      busy_o   = 1'b0;
      done_o   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start_e_i && !flush_e_i) begin
               busy_o = 1'b1;
               op_d   = op_e_i;
               rd_d   = rd_e_i;
               if (div_zero) begin
                  result_d = op_e_i[1] ? src_a_e_i : '1;
                  state_d  = S_DONE;
               end else if (div_ovf) begin
                  result_d = op_e_i[1] ? '0 : MIN_NEG;
                  state_d  = S_DONE;
               end
`ifdef FAST_MUL_EN
               else if (!op_e_i[2]) begin
                  result_d = (op_e_i == OP_MUL) ? fprod[W-1:0] : fprod[2*W-1:W];
                  state_d  = S_DONE;
               end
`endif
               else begin
                  hi_d    = '0;
                  lo_d    = op_e_i[2] ? a_mag : b_mag;
                  opnd_d  = op_e_i[2] ? b_mag : a_mag;
                  negq_d  = a_neg ^ b_neg;
                  negr_d  = a_neg;
                  cnt_d   = CNT_INIT;
                  state_d = S_BUSY;
               end
            end
         end
         S_BUSY: begin
            busy_o = 1'b1;
            hi_d   = hi_n;
            lo_d   = lo_n;
            cnt_d  = cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) begin
               result_d = result_fin;
               state_d  = S_DONE;
            end
         end
         S_DONE: begin
            done_o  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // A flushed instruction must leave no trace on the result interface.
      if (flush_e_i) begin
         state_d  = S_IDLE;
         cnt_d    = '0;
         done_o   = 1'b0;
         result_d = result_q;
         rd_d     = rd_q;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         opnd_q   <= '0;
         op_q     <= '0;
         negq_q   <= 1'b0;
         negr_q   <= 1'b0;
         result_q <= '0;
         rd_q     <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         opnd_q   <= opnd_d;
         op_q     <= op_d;
         negq_q   <= negq_d;
         negr_q   <= negr_d;
         result_q <= result_d;
         rd_q     <= rd_d;
      end
   end

   assign result_o = result_q;
   assign rd_o     = rd_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: divide, special cases, multiply, flush, mid-op reset, held start.
module tb_muldiv_unit;

   logic        clk = 1'b0;
   logic        rst_i, start_e_i, flush_e_i;
   logic [2:0]  op_e_i;
   logic [31:0] src_a_e_i, src_b_e_i;
   logic [4:0]  rd_e_i;
   logic        busy_o, done_o;
   logic [31:0] result_o;
   logic [4:0]  rd_o;

   int n_checks = 0;
   int n_pass   = 0;

`ifdef FAST_MUL_EN
   localparam int MUL_LAT = 1;
`else
   localparam int MUL_LAT = 33;
`endif

   always #5 clk = ~clk;

   muldiv_unit dut (
      .clk_i     (clk),
      .rst_i     (rst_i),
      .start_e_i (start_e_i),
      .op_e_i    (op_e_i),
      .src_a_e_i (src_a_e_i),
      .src_b_e_i (src_b_e_i),
      .rd_e_i    (rd_e_i),
      .flush_e_i (flush_e_i),
      .busy_o    (busy_o),
      .done_o    (done_o),
      .result_o  (result_o),
      .rd_o      (rd_o)
   );

   // Issues one op at a negedge and steps until done_o or the cycle budget expires.
   task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input bit hold_start,
                         output logic [31:0] res, output logic [4:0] rdv,
                         output int lat, output int busy_n, output bit seen);
      @(negedge clk);
      op_e_i = op; src_a_e_i = a; src_b_e_i = b; rd_e_i = rd; start_e_i = 1'b1;
      #1;
      seen = 1'b0; lat = -1; busy_n = 0; res = '0; rdv = '0;
      for (int c = 0; c < 60; c++) begin
         if (done_o) begin
            seen = 1'b1; lat = c; res = result_o; rdv = rd_o;
            break;
         end
         if (busy_o) busy_n++;
         @(negedge clk);
         if (!hold_start) start_e_i = 1'b0;
         #1;
      end
      start_e_i = 1'b0;
   endtask

   task automatic test_reset;
      rst_i = 1'b1; start_e_i = 1'b0; flush_e_i = 1'b0;
      op_e_i = '0; src_a_e_i = '0; src_b_e_i = '0; rd_e_i = '0;
      repeat (2) @(negedge clk);
      #1;
      n_checks++;
      if ({busy_o, done_o, result_o, rd_o} !== 39'd0)
         $display("FAIL reset_outputs got busy=%b done=%b res=%h rd=%0d exp all 0", busy_o, done_o, result_o, rd_o);
      else n_pass++;
      @(negedge clk); rst_i = 1'b0;
   endtask

   task automatic test_div;
      logic [31:0] r; logic [4:0] rd; int lat, bn; bit seen;
      run_op(3'd4, 32'd100, 32'd7, 5'd5, 1'b0, r, rd, lat, bn, seen);
      n_checks++; if (seen !== 1'b1) $display("FAIL div_done_seen got %b exp 1", seen); else n_pass++;
      n_checks++; if (r !== 32'd14) $display("FAIL div_100_7 got %h exp %h", r, 32'd14); else n_pass++;
      n_checks++; if (rd !== 5'd5) $display("FAIL div_rd got %0d exp 5", rd); else n_pass++;
      n_checks++; if (lat != 33) $display("FAIL div_latency got %0d exp 33", lat); else n_pass++;
      n_checks++; if (bn != 33) $display("FAIL div_busy_cycles got %0d exp 33", bn); else n_pass++;
      n_checks++; if (busy_o !== 1'b0) $display("FAIL busy_in_done got %b exp 0", busy_o); else n_pass++;
      @(negedge clk); #1;
      n_checks++; if (done_o !== 1'b0) $display("FAIL done_pulse_width got %b exp 0", done_o); else n_pass++;
      n_checks++; if (result_o !== 32'd14) $display("FAIL result_hold got %h exp %h", result_o, 32'd14); else n_pass++;
      run_op(3'd4, 32'hFFFF_FF9C, 32'd7, 5'd6, 1'b0, r, rd, lat, bn, seen);
      n_checks++; if (r !== 32'hFFFF_FFF2) $display("FAIL div_neg100_7 got %h exp %h", r, 32'hFFFF_FFF2); else n_pass++;
      run_op(3'd6, 32'hFFFF_FF9C, 32'd7, 5'd6, 1'b0, r, rd, lat, bn, seen);
      n_checks++; if (r !== 32'hFFFF_FFFE) $display("FAIL rem_neg100_7 got %h exp %h", r, 32'hFFFF_FFFE); else n_pass++;
   endtask

   task automatic test_special;
      logic [31:0] r; logic [4:0] rd; int lat, bn; bit seen;
      run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd8, 1'b0, r, rd, lat, bn, seen);
      n_checks++; if (r !== 32'hFFFF_FFFF) $display("FAIL rem_neg7_2 got %h exp %h", r, 32'hFFFF_FFFF); else n_pass++;
      run_op(3'd5, 32'd5, 32'd0, 5'd9, 1'b0, r, rd, lat, bn, seen);
      n_checks++; if (r !== 32'hFFFF_FFFF) $display("FAIL divu_by_zero got %h exp %h", r, 32'hFFFF_FFFF); else n_pass++;
      n_checks++; if (lat != 1) $display("FAIL divu_zero_latency got %0d exp 1", lat); else n_pass++;
      n_checks++; if (rd !== 5'd9) $display("FAIL divu_zero_rd got %0d exp 9", rd); else n_pass++;
      run_op(3'd7, 32'd5, 32'd0, 5'd10, 1'b0, r, rd, lat, bn, seen);
      n_checks++; if (r !== 32'd5) $display("FAIL remu_by_zero got %h exp %h", r, 32'd5); else n_pass++;
      n_checks++; if (lat != 1) $display("FAIL remu_zero_latency got %0d exp 1", lat); else n_pass++;
      run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 1'b0, r, rd, lat, bn, seen);
      n_checks++; if (r !== 32'h8000_0000) $display("FAIL div_overflow got %h exp %h", r, 32'h8000_0000); else n_pass++;
      n_checks++; if (lat != 1) $display("FAIL div_overflow_latency got %0d exp 1", lat); else n_pass++;
      run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 1'b0, r, rd, lat, bn, seen);
      n_checks++; if (r !== 32'd0) $display("FAIL rem_overflow got %h exp 0", r); else n_pass++;
      run_op(3'd5, 32'hFFFF_FFFF, 32'd16, 5'd13, 1'b0, r, rd, lat, bn, seen);
      n_checks++; if (r !== 32'h0FFF_FFFF) $display("FAIL divu_large got %h exp %h", r, 32'h0FFF_FFFF); else n_pass++;
   endtask

   task automatic test_mul;
      logic [31:0] r; logic [4:0] rd; int lat, bn; bit seen;
      run_op(3'd1, 32'hFFFF_FFFF, 32'd2, 5'd14, 1'b0, r, rd, lat, bn, seen);
      n_checks++; if (r !== 32'hFFFF_FFFF) $display("FAIL mulh_neg1_2 got %h exp %h", r, 32'hFFFF_FFFF); else n_pass++;
      n_checks++; if (lat != MUL_LAT) $display("FAIL mul_latency got %0d exp %0d", lat, MUL_LAT); else n_pass++;
      run_op(3'd3, 32'hFFFF_FFFF, 32'd2, 5'd15, 1'b0, r, rd, lat, bn, seen);
      n_checks++; if (r !== 32'd1) $display("FAIL mulhu_ff_2 got %h exp 1", r); else n_pass++;
      run_op(3'd0, 32'd3, 32'hFFFF_FFFC, 5'd16, 1'b0, r, rd, lat, bn, seen);
      n_checks++; if (r !== 32'hFFFF_FFF4) $display("FAIL mul_3_neg4 got %h exp %h", r, 32'hFFFF_FFF4); else n_pass++;
      n_checks++; if (rd !== 5'd16) $display("FAIL mul_rd got %0d exp 16", rd); else n_pass++;
      run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd17, 1'b0, r, rd, lat, bn, seen);
      n_checks++; if (r !== 32'hFFFF_FFFF) $display("FAIL mulhsu_mixed got %h exp %h", r, 32'hFFFF_FFFF); else n_pass++;
   endtask

   task automatic test_flush;
      logic [31:0] r; logic [4:0] rd; int lat, bn, dones; bit seen;
      @(negedge clk);
      op_e_i = 3'd4; src_a_e_i = 32'd1000; src_b_e_i = 32'd7; rd_e_i = 5'd3; start_e_i = 1'b1;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk); start_e_i = 1'b0;
      end
      flush_e_i = 1'b1;
      @(negedge clk); flush_e_i = 1'b0; #1;
      n_checks++; if (busy_o !== 1'b0) $display("FAIL flush_busy got %b exp 0", busy_o); else n_pass++;
      dones = 0;
      for (int c = 0; c < 40; c++) begin
         if (done_o) dones++;
         @(negedge clk); #1;
      end
      n_checks++; if (dones != 0) $display("FAIL flush_no_done got %0d pulses exp 0", dones); else n_pass++;
      run_op(3'd4, 32'd9, 32'd3, 5'd7, 1'b0, r, rd, lat, bn, seen);
      n_checks++; if (r !== 32'd3) $display("FAIL div_after_flush got %h exp 3", r); else n_pass++;
      n_checks++; if (lat != 33) $display("FAIL div_after_flush_latency got %0d exp 33", lat); else n_pass++;
      @(negedge clk);
      op_e_i = 3'd4; src_a_e_i = 32'd100; src_b_e_i = 32'd7; rd_e_i = 5'd1;
      start_e_i = 1'b1; flush_e_i = 1'b1; #1;
      n_checks++; if (busy_o !== 1'b0) $display("FAIL flush_start_busy got %b exp 0", busy_o); else n_pass++;
      @(negedge clk); start_e_i = 1'b0; flush_e_i = 1'b0; #1;
      n_checks++; if ({busy_o, done_o} !== 2'b00) $display("FAIL flush_start_idle got %b exp 00", {busy_o, done_o}); else n_pass++;
   endtask

   task automatic test_reset_mid;
      logic [31:0] r; logic [4:0] rd; int lat, bn; bit seen;
      @(negedge clk);
      op_e_i = 3'd3; src_a_e_i = 32'hFFFF_FFFF; src_b_e_i = 32'hFFFF_FFFF; rd_e_i = 5'd20; start_e_i = 1'b1;
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk); start_e_i = 1'b0;
      end
      rst_i = 1'b1;
      @(negedge clk); #1;
      n_checks++;
      if ({busy_o, done_o, result_o, rd_o} !== 39'd0)
         $display("FAIL reset_mid got busy=%b done=%b res=%h rd=%0d exp all 0", busy_o, done_o, result_o, rd_o);
      else n_pass++;
      rst_i = 1'b0;
      run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd21, 1'b0, r, rd, lat, bn, seen);
      n_checks++; if (r !== 32'hFFFF_FFFE) $display("FAIL mulhu_after_reset got %h exp %h", r, 32'hFFFF_FFFE); else n_pass++;
   endtask

   task automatic test_hold_start;
      logic [31:0] r; logic [4:0] rd; int lat, bn; bit seen;
      @(negedge clk);
      op_e_i = 3'd5; src_a_e_i = 32'd42; src_b_e_i = 32'd0; rd_e_i = 5'd22; start_e_i = 1'b1;
      @(negedge clk); #1;
      n_checks++; if (done_o !== 1'b1) $display("FAIL hold_first_done got %b exp 1", done_o); else n_pass++;
      @(negedge clk); start_e_i = 1'b0; #1;
      n_checks++; if ({busy_o, done_o} !== 2'b00) $display("FAIL hold_no_restart got %b exp 00", {busy_o, done_o}); else n_pass++;
      run_op(3'd4, 32'd100, 32'd7, 5'd23, 1'b1, r, rd, lat, bn, seen);
      n_checks++; if (r !== 32'd14 || lat != 33) $display("FAIL hold_div got %h lat %0d exp 14 lat 33", r, lat); else n_pass++;
      @(negedge clk); #1;
      n_checks++; if ({busy_o, done_o} !== 2'b00) $display("FAIL hold_div_no_restart got %b exp 00", {busy_o, done_o}); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_div();
      test_special();
      test_mul();
      test_flush();
      test_reset_mid();
      test_hold_start();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
